z16_decode_stage: RTL and testbench
===================================

Name: z16_decode_stage

Overview:
Registered, handshaked instruction-decode pipeline stage for the Z16 core. It replaces the purely combinational decode path between fetch and execute. It accepts one 16-bit instruction per cycle from fetch with valid/ready and holds the decoded fields in an output register for execute. A register scoreboard stalls on RAW/WAW hazards until writeback releases the register. Supports flush and a saturating stall counter.

Parameters:
IMM_W, 16, width of sign-extended immediate output (>=8)
SB_EN, 1, 1 = scoreboard hazard stalls enabled; 0 = never stall on hazards, o_busy forced 0
CNT_W, 16, width of saturating stall counter

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, synchronous, active-low
i_instr  input  16  instruction from fetch
i_valid  input  1  i_instr valid
o_ready  output  1  stage accepts i_instr this cycle
o_valid  output  1  decoded entry valid toward execute
i_ex_ready  input  1  execute consumes entry this cycle
o_opcode  output  4  decoded opcode
o_rd_addr  output  4  destination register
o_rs1_addr  output  4  source register 1
o_rs2_addr  output  4  source register 2
o_imm  output  IMM_W  sign-extended immediate
o_rd_wen  output  1  register write enable of entry
o_mem_wen  output  1  memory write enable of entry
o_alu_ctrl  output  4  ALU operation
i_wb_en  input  1  writeback retires a register write
i_wb_addr  input  4  register retired by writeback
i_flush  input  1  discard held entry, refuse input this cycle
o_busy  output  16  scoreboard: bit n = write to rn pending
o_stall_cnt  output  CNT_W  cycles with i_valid=1 and o_ready=0 due to hazard

Behaviour:
- One clock; reset is synchronous and active-low (i_rst_n sampled on rising i_clk). While i_rst_n=0: o_ready=0. On reset, all registered outputs, o_busy and o_stall_cnt are 0.
- Decode rules (op = i_instr[3:0]):
  - rd = [7:4].
  - rs1 = [7:4] for op 9; {2'b00,[5:4]} for op E/F; otherwise [11:8].
  - rs2 = {2'b00,[7:6]} for op E/F; otherwise [15:12].
  - imm is sign-extended to IMM_W: [15:8] for op 9/E/F; [15:12] for op A/C/D; [7:4] for op B; otherwise 0.
  - rd_wen = 1 for op<=A, C or D. mem_wen = 1 for op B only.
  - alu_ctrl = op if op<=8, otherwise 0.
- Single-entry output register. Output fire = o_valid & i_ex_ready. Input fire = i_valid & o_ready.
- o_ready = i_rst_n & !i_flush & (!o_valid | i_ex_ready) & !hazard. Combinational; full throughput when there are no hazards.
- hazard (SB_EN=1) = busy_eff[rs1] | busy_eff[rs2] | (rd_wen_new & busy_eff[rd]). busy_eff = o_busy with bit i_wb_addr cleared when i_wb_en=1, so same-cycle writeback releases the register. Both rs fields are always checked; this is conservative.
- Latency: decoded fields appear on outputs 1 cycle after input fire. Fields are stable while o_valid=1 and i_ex_ready=0.
- o_valid next = input fire ? 1 : (output fire ? 0 : o_valid). i_flush forces o_valid next = 0.
- Scoreboard update, evaluated each cycle:
  - Clear bit i_wb_addr if i_wb_en.
  - Set bit rd on input fire with rd_wen. If set and clear target the same bit in one cycle, set wins.
  - On i_flush with o_valid=1 and held o_rd_wen=1, clear bit o_rd_addr. This clear is applied before the wb clear; no input fire can occur that cycle.
- Stall counter: +1 each cycle with i_rst_n=1, i_valid=1, !i_flush, slot free ((!o_valid|i_ex_ready)) and hazard=1. Saturates at all-ones. Backpressure-only stalls are not counted.
- A held entry is not re-checked for hazards; its bits were set at acceptance.
- i_wb_en for a non-busy register: no effect. i_instr is ignored when i_valid=0.

Test Plan:
- Reset, then i_instr=16'hF009, i_valid=1, i_ex_ready=1 -> next cycle o_valid=1, opcode=9, rd=0, rs1=0, imm=16'hFFF0, rd_wen=1, alu_ctrl=0, o_busy=16'h0001.
- 16'h2310 then 16'h5140 back-to-back -> first accepted, o_busy[1]=1. Second is stalled with o_ready=0 and o_stall_cnt increments each cycle. i_wb_en=1, i_wb_addr=1 -> second accepted that same cycle, o_busy=16'h0011.
- 16'h5A2B (store) -> mem_wen=1, rd_wen=0, rs1=A, rs2=5, imm=16'h0002, o_busy unchanged.
- 16'h9C3E (op E) -> rs1=3, rs2=0, imm=16'hFF9C, rd_wen=0. Hold i_ex_ready=0 for 3 cycles -> outputs stable, o_ready=0, o_stall_cnt unchanged.
- Accept 16'h2310, then assert i_flush with o_valid=1 -> o_valid=0 next cycle, o_busy[1]=0, no input accepted in the flush cycle.
- CNT_W=2, hazard held for 6 cycles -> o_stall_cnt=3 and stays 3. Assert i_rst_n=0 mid-stall -> o_stall_cnt=0, o_busy=0, o_valid=0.

Source files
------------

// File: rtl/z16_decode_stage_if.sv
// Fetch/execute/writeback bundle for the Z16 decode stage.
// The slave modport is the decode stage; the master modport is its environment.
interface z16_decode_stage_if #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned CNT_W = 16
);
  // Fetch side
  logic [15:0]      i_instr;
  logic             i_valid;
  logic             o_ready;
  // Execute side
  logic             o_valid;
  logic             i_ex_ready;
  logic [3:0]       o_opcode;
  logic [3:0]       o_rd_addr;
  logic [3:0]       o_rs1_addr;
  logic [3:0]       o_rs2_addr;
  logic [IMM_W-1:0] o_imm;
  logic             o_rd_wen;
  logic             o_mem_wen;
  logic [3:0]       o_alu_ctrl;
  // Writeback, flush and status
  logic             i_wb_en;
  logic [3:0]       i_wb_addr;
  logic             i_flush;
  logic [15:0]      o_busy;
  logic [CNT_W-1:0] o_stall_cnt;

  modport master (
    output i_instr, i_valid, i_ex_ready, i_wb_en, i_wb_addr, i_flush,
    input  o_ready, o_valid, o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm,
           o_rd_wen, o_mem_wen, o_alu_ctrl, o_busy, o_stall_cnt
  );

  modport slave (
    input  i_instr, i_valid, i_ex_ready, i_wb_en, i_wb_addr, i_flush,
    output o_ready, o_valid, o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm,
           o_rd_wen, o_mem_wen, o_alu_ctrl, o_busy, o_stall_cnt
  );
endinterface

// File: rtl/z16_decode_stage.sv
// Z16 registered decode stage: valid/ready input from fetch, single-entry output
// register toward execute, register scoreboard for RAW/WAW stalls, flush and a
// saturating hazard-stall counter.
module z16_decode_stage #(
  parameter int unsigned IMM_W = 16,
  parameter bit          SB_EN = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  z16_decode_stage_if.slave io_bus
);

  logic [3:0]       w_op;
  logic [3:0]       w_rd;
  logic [3:0]       w_rs1;
  logic [3:0]       w_rs2;
  logic [IMM_W-1:0] w_imm;
  logic [IMM_W-1:0] w_imm_hi8;
  logic [IMM_W-1:0] w_imm_hi4;
  logic [IMM_W-1:0] w_imm_mid4;
  logic             w_rd_wen;
  logic             w_mem_wen;
  logic [3:0]       w_alu_ctrl;

  logic [15:0]      w_busy_eff;
  logic [15:0]      w_busy_nxt;
  logic             w_hazard;
  logic             w_slot_free;
  logic             w_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_stall;

  logic             r_valid;
  logic [3:0]       r_opcode;
  logic [3:0]       r_rd_addr;
  logic [3:0]       r_rs1_addr;
  logic [3:0]       r_rs2_addr;
  logic [IMM_W-1:0] r_imm;
  logic             r_rd_wen;
  logic             r_mem_wen;
  logic [3:0]       r_alu_ctrl;
  logic [15:0]      r_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_op       = io_bus.i_instr[3:0];
  assign w_rd       = io_bus.i_instr[7:4];
  assign w_imm_hi8  = IMM_W'($signed(io_bus.i_instr[15:8]));
  assign w_imm_hi4  = IMM_W'($signed(io_bus.i_instr[15:12]));
  assign w_imm_mid4 = IMM_W'($signed(io_bus.i_instr[7:4]));
  assign w_rd_wen   = (w_op <= 4'hA) || (w_op == 4'hC) || (w_op == 4'hD);
  assign w_mem_wen  = (w_op == 4'hB);
  assign w_alu_ctrl = (w_op <= 4'h8) ? w_op : 4'h0;

  // Opcode-dependent source fields and immediate
  always_comb begin
    w_rs1 = io_bus.i_instr[11:8];
    w_rs2 = io_bus.i_instr[15:12];
    w_imm = '0;
    case (w_op)
      4'h9: begin
        w_rs1 = io_bus.i_instr[7:4];
        w_imm = w_imm_hi8;
      end
      4'hE, 4'hF: begin
        w_rs1 = {2'b00, io_bus.i_instr[5:4]};
        w_rs2 = {2'b00, io_bus.i_instr[7:6]};
        w_imm = w_imm_hi8;
      end
      4'hA, 4'hC, 4'hD: w_imm = w_imm_hi4;
      4'hB:             w_imm = w_imm_mid4;
      default:          ;
    endcase
  end

  // Same-cycle writeback release is visible to the hazard check
  always_comb begin
    w_busy_eff = r_busy;
    if (io_bus.i_wb_en) begin
      w_busy_eff[io_bus.i_wb_addr] = 1'b0;
    end
  end

  // Both rs fields are checked regardless of opcode (conservative)
  assign w_hazard    = SB_EN && (w_busy_eff[w_rs1] || w_busy_eff[w_rs2] ||
                                 (w_rd_wen && w_busy_eff[w_rd]));
  assign w_slot_free = !r_valid || io_bus.i_ex_ready;
  assign w_ready     = i_rst_n && !io_bus.i_flush && w_slot_free && !w_hazard;
  assign w_in_fire   = io_bus.i_valid && w_ready;
  assign w_out_fire  = r_valid && io_bus.i_ex_ready;
  assign w_stall     = io_bus.i_valid && !io_bus.i_flush && w_slot_free && w_hazard;

  // Scoreboard next state: flush clear, then wb clear, then acceptance set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (io_bus.i_flush && r_valid && r_rd_wen) begin
      w_busy_nxt[r_rd_addr] = 1'b0;
    end
    if (io_bus.i_wb_en) begin
      w_busy_nxt[io_bus.i_wb_addr] = 1'b0;
    end
    if (w_in_fire && w_rd_wen) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
    if (!SB_EN) begin
      w_busy_nxt = '0;
    end
  end

  // Output entry register: load on accept, drop on consume or flush
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_rd_addr  <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_imm      <= '0;
      r_rd_wen   <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_alu_ctrl <= '0;
    end else begin
      if (io_bus.i_flush) begin
        r_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_opcode   <= w_op;
        r_rd_addr  <= w_rd;
        r_rs1_addr <= w_rs1;
        r_rs2_addr <= w_rs2;
        r_imm      <= w_imm;
        r_rd_wen   <= w_rd_wen;
        r_mem_wen  <= w_mem_wen;
        r_alu_ctrl <= w_alu_ctrl;
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Saturating count of hazard-only stall cycles
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign io_bus.o_ready     = w_ready;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_opcode    = r_opcode;
  assign io_bus.o_rd_addr   = r_rd_addr;
  assign io_bus.o_rs1_addr  = r_rs1_addr;
  assign io_bus.o_rs2_addr  = r_rs2_addr;
  assign io_bus.o_imm       = r_imm;
  assign io_bus.o_rd_wen    = r_rd_wen;
  assign io_bus.o_mem_wen   = r_mem_wen;
  assign io_bus.o_alu_ctrl  = r_alu_ctrl;
  assign io_bus.o_busy      = r_busy;
  assign io_bus.o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Bench for z16_decode_stage: directed scenarios plus randomized traffic, checked
// against a queue-based reference model. A second instance with CNT_W=2 shares
// all inputs and covers counter saturation.
module tb_z16_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        rd_wen;
    logic        mem_wen;
    logic [3:0]  alu;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  bit [15:0] m_busy;
  dec_t      m_q[$];
  int        m_cnt;
  int        m_cnt2;

  always #5 clk = ~clk;

  z16_decode_stage_if #(.IMM_W(16), .CNT_W(16)) ifc ();
  z16_decode_stage_if #(.IMM_W(16), .CNT_W(2))  ifc2 ();

  assign ifc2.i_instr    = ifc.i_instr;
  assign ifc2.i_valid    = ifc.i_valid;
  assign ifc2.i_ex_ready = ifc.i_ex_ready;
  assign ifc2.i_wb_en    = ifc.i_wb_en;
  assign ifc2.i_wb_addr  = ifc.i_wb_addr;
  assign ifc2.i_flush    = ifc.i_flush;

  z16_decode_stage #(.IMM_W(16), .SB_EN(1'b1), .CNT_W(16)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (ifc)
  );

  z16_decode_stage #(.IMM_W(16), .SB_EN(1'b1), .CNT_W(2)) u_dut2 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (ifc2)
  );

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Decode straight from the instruction-format rules
  function automatic dec_t decode(input logic [15:0] ins);
    dec_t d;
    int   op;
    op        = int'(ins[3:0]);
    d.op      = ins[3:0];
    d.rd      = ins[7:4];
    d.rs1     = ins[11:8];
    d.rs2     = ins[15:12];
    d.imm     = 16'h0000;
    if (op == 9) d.rs1 = ins[7:4];
    if (op >= 14) begin
      d.rs1 = {2'b00, ins[5:4]};
      d.rs2 = {2'b00, ins[7:6]};
    end
    if (op == 9 || op >= 14)                d.imm = 16'(sext(int'(ins[15:8]), 8));
    else if (op == 10 || op == 12 || op == 13) d.imm = 16'(sext(int'(ins[15:12]), 4));
    else if (op == 11)                      d.imm = 16'(sext(int'(ins[7:4]), 4));
    d.rd_wen  = (op <= 10) || (op == 12) || (op == 13);
    d.mem_wen = (op == 11);
    d.alu     = (op <= 8) ? ins[3:0] : 4'h0;
    return d;
  endfunction

  function automatic bit m_hazard();
    bit [15:0] be;
    dec_t      d;
    be = m_busy;
    if (ifc.i_wb_en === 1'b1) be[ifc.i_wb_addr] = 1'b0;
    d = decode(ifc.i_instr);
    return be[d.rs1] || be[d.rs2] || (d.rd_wen && be[d.rd]);
  endfunction

  function automatic bit m_ready();
    bit free;
    free = (m_q.size() == 0) || (ifc.i_ex_ready === 1'b1);
    return (rst_n === 1'b1) && (ifc.i_flush !== 1'b1) && free && !m_hazard();
  endfunction

  function automatic dec_t m_head();
    return (m_q.size() != 0) ? m_q[0] : '0;
  endfunction

  function automatic dec_t dut_fields();
    return {ifc.o_opcode, ifc.o_rd_addr, ifc.o_rs1_addr, ifc.o_rs2_addr, ifc.o_imm,
            ifc.o_rd_wen, ifc.o_mem_wen, ifc.o_alu_ctrl};
  endfunction

  task automatic drive(input logic [15:0] ins, input logic v, input logic ex,
                       input logic wb, input logic [3:0] wa, input logic fl);
    ifc.i_instr    = ins;
    ifc.i_valid    = v;
    ifc.i_ex_ready = ex;
    ifc.i_wb_en    = wb;
    ifc.i_wb_addr  = wa;
    ifc.i_flush    = fl;
  endtask

  // One clock: advance the model with the inputs present at the edge
  task automatic step();
    dec_t d;
    bit   hz, free, fin;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_busy = '0;
      m_q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      d    = decode(ifc.i_instr);
      hz   = m_hazard();
      free = (m_q.size() == 0) || ifc.i_ex_ready;
      fin  = ifc.i_valid && m_ready();
      if (ifc.i_valid && !ifc.i_flush && free && hz) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (ifc.i_flush && m_q.size() != 0 && m_q[0].rd_wen) m_busy[m_q[0].rd] = 1'b0;
      if (ifc.i_wb_en) m_busy[ifc.i_wb_addr] = 1'b0;
      if (fin && d.rd_wen) m_busy[d.rd] = 1'b1;
      if (ifc.i_flush) m_q.delete();
      else begin
        if (m_q.size() != 0 && ifc.i_ex_ready) void'(m_q.pop_front());
        if (fin) m_q.push_back(d);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    step();
    n_checks++;
    if (ifc.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ifc.o_ready);
    end
    n_checks++;
    if (ifc.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", ifc.o_valid);
    end
    n_checks++;
    if (ifc.o_busy !== 16'h0000) begin
      n_fail++; $display("FAIL reset_busy: got %h want 0000", ifc.o_busy);
    end
    n_checks++;
    if (ifc.o_stall_cnt !== 16'h0000 || ifc2.o_stall_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", ifc.o_stall_cnt, ifc2.o_stall_cnt);
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_basic();
    dec_t exp;
    drive(16'hF009, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    #1;
    n_checks++;
    if (ifc.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b want 1", ifc.o_ready);
    end
    step();
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    exp = '{op: 4'h9, rd: 4'h0, rs1: 4'h0, rs2: 4'hF, imm: 16'hFFF0,
            rd_wen: 1'b1, mem_wen: 1'b0, alu: 4'h0};
    n_checks++;
    if (ifc.o_valid !== 1'b1 || dut_fields() !== exp || m_head() !== exp) begin
      n_fail++; $display("FAIL basic_fields: got v=%b %h want v=1 %h", ifc.o_valid, dut_fields(), exp);
    end
    n_checks++;
    if (ifc.o_busy !== 16'h0001) begin
      n_fail++; $display("FAIL basic_busy: got %h want 0001", ifc.o_busy);
    end
  endtask

  task automatic test_raw_stall();
    drive(16'h2310, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    n_checks++;
    if (ifc.o_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL raw_busy1: got %b want 1", ifc.o_busy[1]);
    end
    drive(16'h5140, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ifc.o_ready !== 1'b0) begin
        n_fail++; $display("FAIL raw_stall_ready[%0d]: got %b want 0", i, ifc.o_ready);
      end
      step();
      n_checks++;
      if (ifc.o_stall_cnt !== 16'(i + 1)) begin
        n_fail++; $display("FAIL raw_stall_cnt[%0d]: got %0d want %0d", i, ifc.o_stall_cnt, i + 1);
      end
    end
    drive(16'h5140, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0);
    #1;
    n_checks++;
    if (ifc.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_wb_release: got %b want 1", ifc.o_ready);
    end
    step();
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    n_checks++;
    if (ifc.o_busy !== 16'h0011 || ifc.o_busy !== m_busy) begin
      n_fail++; $display("FAIL raw_busy_after: got %h want 0011", ifc.o_busy);
    end
    n_checks++;
    if (ifc.o_valid !== 1'b1 || dut_fields() !== decode(16'h5140)) begin
      n_fail++; $display("FAIL raw_second_fields: got %h want %h", dut_fields(), decode(16'h5140));
    end
  endtask

  task automatic test_store();
    dec_t exp;
    drive(16'h5A2B, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    exp = '{op: 4'hB, rd: 4'h2, rs1: 4'hA, rs2: 4'h5, imm: 16'h0002,
            rd_wen: 1'b0, mem_wen: 1'b1, alu: 4'h0};
    n_checks++;
    if (ifc.o_valid !== 1'b1 || dut_fields() !== exp) begin
      n_fail++; $display("FAIL store_fields: got %h want %h", dut_fields(), exp);
    end
    n_checks++;
    if (ifc.o_busy !== 16'h0011) begin
      n_fail++; $display("FAIL store_busy: got %h want 0011", ifc.o_busy);
    end
  endtask

  task automatic test_hold();
    dec_t exp;
    int   cnt_before;
    drive(16'h0000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    step();
    drive(16'h0000, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0);
    step();
    drive(16'h9C3E, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    exp = '{op: 4'hE, rd: 4'h3, rs1: 4'h3, rs2: 4'h0, imm: 16'hFF9C,
            rd_wen: 1'b0, mem_wen: 1'b0, alu: 4'h0};
    cnt_before = m_cnt;
    drive(16'h1234, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ifc.o_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", i, ifc.o_ready);
      end
      step();
      n_checks++;
      if (ifc.o_valid !== 1'b1 || dut_fields() !== exp) begin
        n_fail++; $display("FAIL hold_fields[%0d]: got %h want %h", i, dut_fields(), exp);
      end
      n_checks++;
      if (ifc.o_stall_cnt !== 16'(cnt_before)) begin
        n_fail++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", i, ifc.o_stall_cnt, cnt_before);
      end
    end
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
  endtask

  task automatic test_flush();
    drive(16'h2310, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    drive(16'h0050, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    #1;
    n_checks++;
    if (ifc.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %b want 0", ifc.o_ready);
    end
    step();
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    n_checks++;
    if (ifc.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", ifc.o_valid);
    end
    n_checks++;
    if (ifc.o_busy !== 16'h0000) begin
      n_fail++; $display("FAIL flush_busy: got %h want 0000", ifc.o_busy);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(16'h2310, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step();
    drive(16'h5140, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (ifc2.o_stall_cnt !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        n_fail++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", i, ifc2.o_stall_cnt,
                           (i + 1 > 3) ? 3 : i + 1);
      end
    end
    n_checks++;
    if (ifc.o_stall_cnt !== 16'd6) begin
      n_fail++; $display("FAIL sat_cnt16: got %0d want 6", ifc.o_stall_cnt);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (ifc2.o_stall_cnt !== 2'd0 || ifc2.o_busy !== 16'h0000 || ifc2.o_valid !== 1'b0 ||
        ifc.o_stall_cnt !== 16'd0 || ifc.o_busy !== 16'h0000 || ifc.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL sat_reset: got cnt=%0d busy=%h v=%b want 0 0000 0",
                         ifc2.o_stall_cnt, ifc2.o_busy, ifc2.o_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
      #1;
      n_checks++;
      if (ifc.o_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ifc.o_ready, m_ready());
      end
      step();
      n_checks++;
      if (ifc.o_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && dut_fields() !== m_head())) begin
        n_fail++; $display("FAIL rand_entry[%0d]: got v=%b %h want v=%b %h", i, ifc.o_valid,
                           dut_fields(), m_q.size() != 0, m_head());
      end
      n_checks++;
      if (ifc.o_busy !== m_busy || ifc.o_stall_cnt !== 16'(m_cnt) ||
          ifc2.o_stall_cnt !== 2'(m_cnt2)) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, ifc.o_busy,
                           ifc.o_stall_cnt, ifc2.o_stall_cnt, m_busy, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    drive(16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    test_reset();
    test_basic();
    test_raw_stall();
    test_store();
    test_hold();
    test_flush();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
